// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the 8-bit restoring divider.
package divider_pkg;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;
endpackage

// File: rtl/divider_8_sub.sv
// 9-bit trial subtractor for one restoring-division step.
// Combinational, zero latency; no handshake.
// borrow is set when a < b, i.e. the trial subtraction must be undone.
module sub_8 (
   input  logic [8:0] a,
   input  logic [8:0] b,
   output logic [8:0] diff,
   output logic       borrow
);
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/divider_8.sv
// Multi-cycle restoring divider, one quotient bit per cycle; DIVIDER_8_SIGNED_EN adds signed mode.
// Latency 9 cycles start->done, one division per 10 cycles.
// No queueing: start is only sampled in IDLE, the pipeline stalls on busy.
module divider_8 #(
   parameter int WIDTH = divider_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_8_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);
   import divider_pkg::*;

   div_state_t       state, state_nxt;
   logic             accept, last;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] qreg, dvs, q_nxt, op_a, op_b, q_out, r_out;
   logic [WIDTH:0]   rem, shifted, diff, rem_nxt;
   logic             borrow, dz;

   // The stored remainder never exceeds the divisor, so its top bit drops out of the shift.
   assign shifted = (WIDTH+1)'({rem, qreg[WIDTH-1]});

   sub_8 u_sub (
      .a      (shifted),
      .b      ({1'b0, dvs}),
      .diff   (diff),
      .borrow (borrow)
   );

   assign rem_nxt = borrow ? shifted : diff;
   assign q_nxt   = {qreg[WIDTH-2:0], ~borrow};
   assign last    = (cnt == CNT_W'(WIDTH-1));

`ifdef DIVIDER_8_SIGNED_EN
   logic neg_a, neg_b, neg_q, neg_r;
   assign neg_a = is_signed & dividend[WIDTH-1];
   assign neg_b = is_signed & divisor[WIDTH-1];
   assign op_a  = neg_a ? -dividend : dividend;
   assign op_b  = neg_b ? -divisor : divisor;
   assign q_out = neg_q ? -q_nxt : q_nxt;
   assign r_out = neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
`else
   assign op_a  = dividend;
   assign op_b  = divisor;
   assign q_out = q_nxt;
   assign r_out = rem_nxt[WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qreg      <= '0;
         rem       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         dz        <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
`ifdef DIVIDER_8_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else if (accept) begin
         qreg <= op_a;
         rem  <= '0;
         dvs  <= op_b;
         cnt  <= '0;
         dz   <= (divisor == '0);
`ifdef DIVIDER_8_SIGNED_EN
         // Divide-by-zero keeps the raw all-ones quotient, so only the remainder follows the sign.
         neg_q <= (neg_a ^ neg_b) & (divisor != '0);
         neg_r <= neg_a;
`endif
      end else if (state == RUN) begin
         qreg <= q_nxt;
         rem  <= rem_nxt;
         cnt  <= cnt + 1'b1;
         if (last) begin
            quotient  <= q_out;
            remainder <= r_out;
            div_zero  <= dz;
         end
      end
   end
endmodule

// File: tb/tb_divider_8.sv
// Directed-vector bench for divider_8: timing, edge operands, ignored start, mid-run reset.
module tb_divider_8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       sgn = 1'b0;
   logic       busy, done, div_zero;
   logic [7:0] quotient, remainder;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] last_q = '0;

   always #5 clk = ~clk;

   divider_8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIVIDER_8_SIGNED_EN
      .is_signed (sgn),
`endif
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Starts a division, then counts negedges until done (bounded) and checks timing and results.
   task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz);
      int   busy_n = 0;
      int   lat = 0;
      logic both = 1'b0;
      @(negedge clk);
      dividend = a; divisor = b; sgn = s; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (busy && done) both = 1'b1;
         if (c == 4) chk({tag, "_hold_q"}, quotient, last_q);
         if (done) lat = c;
      end
      chk({tag, "_latency"}, lat, 9);
      chk({tag, "_busy_cycles"}, busy_n, 8);
      chk({tag, "_busy_done_overlap"}, both, 0);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dz"}, div_zero, edz);
      last_q = eq;
   endtask

   initial begin
      int got;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 8'h00);
      chk("rst_r", remainder, 8'h00);
      chk("rst_dz", div_zero, 0);
      rst_n = 1'b1;

      run_div("u200_7", 8'd200, 8'd7, 1'b0, 8'h1C, 8'h04, 1'b0);
      run_div("u255_1", 8'd255, 8'd1, 1'b0, 8'hFF, 8'h00, 1'b0);
      run_div("u3_10", 8'd3, 8'd10, 1'b0, 8'h00, 8'h03, 1'b0);
      run_div("u5_0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'h05, 1'b1);

      // Reset in cycle 4 of a division clears everything immediately.
      @(negedge clk);
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_q", quotient, 8'h00);
      chk("mrst_r", remainder, 8'h00);
      chk("mrst_dz", div_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_idle_busy", busy, 0);
      last_q = 8'h00;
      run_div("u9_3", 8'd9, 8'd3, 1'b0, 8'h03, 8'h00, 1'b0);

      // start during RUN (cycle 3) and DONE (cycle 9) is dropped; cycle 10 start is taken.
      @(negedge clk);
      dividend = 8'd100; divisor = 8'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 3 || c == 9) begin
            dividend = 8'd77; divisor = 8'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (c == 9) begin
            chk("ign_done", done, 1);
            chk("ign_q", quotient, 8'h0B);
            chk("ign_r", remainder, 8'h01);
         end
      end
      @(negedge clk);
      chk("ign_idle_busy", busy, 0);
      chk("ign_idle_q", quotient, 8'h0B);
      dividend = 8'd50; divisor = 8'd6; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("c10_accept_busy", busy, 1);
      got = 0;
      for (int c = 2; c <= 20 && got == 0; c++) begin
         @(negedge clk);
         if (done) got = c;
      end
      chk("c10_latency", got, 9);
      chk("c10_q", quotient, 8'h08);
      chk("c10_r", remainder, 8'h02);
      last_q = 8'h08;

`ifdef DIVIDER_8_SIGNED_EN
      run_div("s_m7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
      run_div("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
      run_div("s_m5_0", 8'hFB, 8'h00, 1'b1, 8'hFF, 8'hFB, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
